// File: rtl/acos_pkg.sv
// Shared types and constants for the acos_search block.
//   THETA_W / X_W : widths of the Q3.7 angle and the Q2.14 cosine
//   THETA_PI      : largest legal angle code, floor(pi * 2^7)
//   X_MAX / X_MIN : Q2.14 codes of +1.0 / -1.0
package acos_pkg;
   localparam int THETA_W  = 10;
   localparam int X_W      = 16;
   localparam int THETA_PI = 402;
   localparam int X_MAX    = 16384;
   localparam int X_MIN    = -16384;

   typedef enum logic [1:0] {IDLE, SEARCH, ROUND, DONE} acos_state_t;
   typedef logic signed [15:0] q2_14_t;
   typedef logic [9:0]         q3_7_t;
endpackage

// File: rtl/acos_search_cos_lut.sv
// Combinational cosine lookup: Q3.7 angle in, Q2.14 cosine out.
//   theta   : angle code, theta/128 radians
//   cos_val : floor(cos(theta/128) * 2^14)
// The table is built at elaboration by a fixed-point Taylor series carried
// at 2^-40 resolution, so the floor to 2^-14 is exact for every entry.
// Codes of 512 and above (4 rad and beyond) lie outside the table and read 0.
module acos_search_cos_lut
   import acos_pkg::*;
(
   input  q3_7_t  theta,
   output q2_14_t cos_val
);
   // cos(i/128): each term is the previous one times -(i/128)^2 / ((2n-1)(2n)).
   // (i/128)^2 = i*i / 2^14, folded into a single division per step.
   function automatic q2_14_t cos_code(input int i);
      longint sq, term, sum;
      sq   = longint'(i) * longint'(i);
      term = longint'(1) <<< 40;
      sum  = term;
      for (int n = 1; n <= 14; n++) begin
         term = -(term * sq) / (longint'(16384) * longint'((2 * n - 1) * (2 * n)));
         sum  = sum + term;
      end
      return q2_14_t'(sum >>> 26);
   endfunction

   q2_14_t rom [512];

   for (genvar g = 0; g < 512; g++) begin : g_rom
      localparam q2_14_t COS_G = cos_code(g);
      assign rom[g] = COS_G;
   end

   assign cos_val = theta[9] ? '0 : rom[theta[8:0]];
endmodule

// File: rtl/acos_search.sv
// acos_search: recovers theta in [0, pi] (Q3.7) from a Q2.14 cosine by a
// successive-approximation search over the cos lookup, one result bit per cycle.
//   Clk, Reset_n         : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, x_in sampled only at accept
//   x_in                 : signed Q2.14 cosine
//   out_valid / out_ready: result handshake, result held until accepted
//   theta_out            : largest angle code with cos(theta) >= x (MSB always 0)
//   sat_out              : x_in was outside [-1.0, +1.0]
// Build option ACOS_ROUND_NEAREST_EN: adds a ROUND cycle that moves the result
// up one code when that cosine is strictly closer to x.
module acos_search
   import acos_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [X_W-1:0]  x_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [THETA_W-1:0]     theta_out,
   output logic                   sat_out
);
   localparam logic [8:0] R_PI = 9'(THETA_PI);
   localparam q2_14_t     X_HI = q2_14_t'(X_MAX);
   localparam q2_14_t     X_LO = q2_14_t'(X_MIN);

   acos_state_t state_q, state_d;
   q2_14_t      x_q, x_d;
   logic [8:0]  r_q, r_d;
   logic [3:0]  k_q, k_d;
   logic        sat_q, sat_d;

   logic [8:0]  cand;
   logic        take;
   q3_7_t       lut_addr;
   q2_14_t      cos_val;

   acos_search_cos_lut u_cos_lut (
      .theta   (lut_addr),
      .cos_val (cos_val)
   );

   assign cand = r_q | (9'd1 << k_q);
   // cos is non-increasing on [0, pi], so "cos(cand) >= x" means cand is not
   // past the answer and the bit can be kept.
   assign take = (cand <= R_PI) && (cos_val >= x_q);

`ifdef ACOS_ROUND_NEAREST_EN
   q2_14_t           cos_r_q, cos_r_d;
   logic signed [X_W:0] d_up, d_dn;
   logic [X_W:0]     mag_up, mag_dn;
   logic             round_up;

   assign lut_addr = (state_q == ROUND) ? {1'b0, r_q + 9'd1} : {1'b0, cand};

   always_comb begin
      d_up     = {x_q[X_W-1], x_q} - {cos_val[X_W-1], cos_val};
      d_dn     = {cos_r_q[X_W-1], cos_r_q} - {x_q[X_W-1], x_q};
      mag_up   = d_up[X_W] ? -d_up : d_up;
      mag_dn   = d_dn[X_W] ? -d_dn : d_dn;
      // Strictly closer only: a tie keeps the floor result.
      round_up = !sat_q && (r_q < R_PI) && (mag_up < mag_dn);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) cos_r_q <= '0;
      else          cos_r_q <= cos_r_d;
   end
`else
   assign lut_addr = {1'b0, cand};
`endif

   // State and datapath registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         r_q     <= '0;
         k_q     <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         r_q     <= r_d;
         k_q     <= k_d;
         sat_q   <= sat_d;
      end
   end

   // Next state and datapath
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      r_d     = r_q;
      k_d     = k_q;
      sat_d   = sat_q;
`ifdef ACOS_ROUND_NEAREST_EN
      cos_r_d = cos_r_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SEARCH;
               x_d     = x_in;
               r_d     = '0;
               k_d     = 4'd8;
               sat_d   = (x_in > X_HI) || (x_in < X_LO);
`ifdef ACOS_ROUND_NEAREST_EN
               // cos(0) is exactly +1.0, so it is known without a lookup.
               cos_r_d = X_HI;
`endif
            end
         end
         SEARCH: begin
            if (take) begin
               r_d = cand;
`ifdef ACOS_ROUND_NEAREST_EN
               cos_r_d = cos_val;
`endif
            end
            if (k_q == 4'd0) begin
`ifdef ACOS_ROUND_NEAREST_EN
               state_d = ROUND;
`else
               state_d = DONE;
`endif
            end else begin
               k_d = k_q - 4'd1;
            end
         end
`ifdef ACOS_ROUND_NEAREST_EN
         ROUND: begin
            if (round_up) r_d = r_q + 9'd1;
            state_d = DONE;
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      theta_out = {1'b0, r_q};
      sat_out   = sat_q;
   end
endmodule

// File: tb/tb_acos_search.sv
// Randomised scoreboard bench for acos_search. Expected results come from a
// real-valued cosine model: largest code i <= 402 with floor(cos(i/128)*2^14) >= x.
module tb_acos_search;
`ifdef ACOS_ROUND_NEAREST_EN
   localparam int LAT = 10;
`else
   localparam int LAT = 9;
`endif
   localparam int ISSUE = LAT + 2;

   logic               Clk = 1'b0;
   logic               Reset_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] x_in = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [9:0]         theta_out;
   logic               sat_out;

   acos_search dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .theta_out (theta_out),
      .sat_out   (sat_out)
   );

   always #5 Clk = ~Clk;

   typedef struct {int theta; int sat;} exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int  chk_cnt = 0;
   int  pass_cnt = 0;
   int  cyc = 0;
   int  last_acc = 0;
   int  prev_acc = 0;
   bit  seen_v = 0;
   bit  rnd_bp = 0;
   int  cos_tab [0:402];

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic int ref_theta(input int x);
      int r = 0;
      for (int i = 0; i <= 402; i++)
         if (cos_tab[i] >= x) r = i;
`ifdef ACOS_ROUND_NEAREST_EN
      if (!(x > 16384 || x < -16384) && r < 402) begin
         int du = x - cos_tab[r + 1];
         int dd = cos_tab[r] - x;
         if (du < 0) du = -du;
         if (dd < 0) dd = -dd;
         if (du < dd) r = r + 1;
      end
`endif
      return r;
   endfunction

   // Issue one x; exp_th < 0 means take the expectation from the model.
   task automatic send(input int x, input int exp_th, input bit chk_iv);
      int w = 0;
      exp_t e;
      in_valid = 1'b1;
      x_in     = 16'(x);
      while (!in_ready && w < 200) begin step(); w++; end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      step();
      prev_acc = last_acc;
      last_acc = cyc;
      in_valid = 1'b0;
      x_in     = 16'($urandom);
      e.theta  = (exp_th < 0) ? ref_theta(x) : exp_th;
      e.sat    = (x > 16384 || x < -16384) ? 1 : 0;
      sb.push_back(e);
      chk("in_ready_after_accept", int'(in_ready), 0);
      if (chk_iv) chk("issue_interval", last_acc - prev_acc, ISSUE);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() > 0 && w < 400) begin step(); w++; end
      if (sb.size() > 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   // Monitor: latency on the first cycle of out_valid, results at each handshake
   always @(negedge Clk) begin
      if (Reset_n && out_valid) begin
         if (!seen_v) begin
            chk("latency", cyc - last_acc, LAT);
            seen_v = 1;
         end
         if (out_ready) begin
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else begin
               mon_e = sb.pop_front();
               chk("theta", int'(theta_out), mon_e.theta);
               chk("sat", int'(sat_out), mon_e.sat);
            end
            seen_v = 0;
         end
      end
   end

   always @(posedge Clk) begin
      if (rnd_bp) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int w;
      for (int i = 0; i <= 402; i++)
         cos_tab[i] = $rtoi($floor($cos(real'(i) / 128.0) * 16384.0));

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_theta", int'(theta_out), 0);
      chk("rst_sat", int'(sat_out), 0);
      Reset_n = 1'b1;
      step();

      // Directed points
      send(16384, 0, 0);
      drain();
      send(0, 201, 0);
      drain();
      send(8192, 134, 0);
      drain();
      send(20000, 0, 0);
      drain();

      // Saturated low with back-pressure; in_valid pulses must be ignored
      out_ready = 1'b0;
      send(-20000, 402, 0);
      w = 0;
      while (!out_valid && w < 50) begin step(); w++; end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x_in     = 16'($urandom);
         step();
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_theta", int'(theta_out), 402);
         chk("hold_sat", int'(sat_out), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b1;
      drain();
      step();
      step();
      chk("no_stray_accept", int'(out_valid), 0);
      chk("idle_in_ready", int'(in_ready), 1);

      // Asynchronous reset in the middle of a search
      send(0, 201, 0);
      repeat (3) step();
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_theta", int'(theta_out), 0);
      chk("arst_sat", int'(sat_out), 0);
      sb.delete();
      step();
      Reset_n = 1'b1;
      step();
      send(8192, 134, 0);
      drain();

      // Sweep every 64th code, back to back, checking the issue interval
      out_ready = 1'b1;
      for (int x = -16384; x <= 16384; x += 64)
         send(x, -1, x != -16384);
      drain();

      // Random full-range inputs under random back-pressure
      rnd_bp = 1;
      for (int i = 0; i < 40; i++)
         send(int'($signed(16'($urandom))), -1, 0);
      drain();
      rnd_bp = 0;
      step();
      step();
      out_ready = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
